// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter for the register file's single write port.
// Each requester owns a one-entry holding slot; same-address writes commit in arrival order.
module regfile_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int RR     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              v0,
    output logic              rdy0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    input  logic              v1,
    output logic              rdy1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    output logic              we3,
    output logic [ADDR_W-1:0] a3,
    output logic [DATA_W-1:0] wd3,
    output logic              haz1,
    output logic              haz2
);

    localparam bit RR_EN = (RR != 0);

    logic              s0_v, s1_v;
    logic [ADDR_W-1:0] s0_a, s1_a;
    logic [DATA_W-1:0] s0_d, s1_d;
    // age = 1: slot 1 is the older entry; lg = 1: port 1 was granted last
    logic              age;
    logic              lg;
    logic              g0, g1;
    logic              ld0, ld1;

    // Grant depends on slot state only, so rdy never combinationally loops through the inputs.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (s0_v && s1_v) begin
            if (s0_a == s1_a) begin
                g0 = !age;
                g1 = age;
            end else if (RR_EN) begin
                g0 = lg;
                g1 = !lg;
            end else begin
                g0 = 1'b1;
            end
        end else begin
            g0 = s0_v;
            g1 = s1_v;
        end
    end

    assign rdy0 = !s0_v || g0;
    assign rdy1 = !s1_v || g1;
    assign ld0  = v0 && rdy0 && (addr0 != '0);
    assign ld1  = v1 && rdy1 && (addr1 != '0);

    assign we3 = g0 || g1;
    assign a3  = g0 ? s0_a : (g1 ? s1_a : '0);
    assign wd3 = g0 ? s0_d : (g1 ? s1_d : '0);

    // The slot being written this cycle still counts: the register file only sees it after the edge.
    assign haz1 = (a1 != '0) && ((s0_v && (s0_a == a1)) || (s1_v && (s1_a == a1)));
    assign haz2 = (a2 != '0) && ((s0_v && (s0_a == a2)) || (s1_v && (s1_a == a2)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_v <= 1'b0;
            s0_a <= '0;
            s0_d <= '0;
            s1_v <= 1'b0;
            s1_a <= '0;
            s1_d <= '0;
            age  <= 1'b0;
            lg   <= 1'b1;
        end else begin
            if (ld0) begin
                s0_v <= 1'b1;
                s0_a <= addr0;
                s0_d <= data0;
            end else if (g0) begin
                s0_v <= 1'b0;
            end
            if (ld1) begin
                s1_v <= 1'b1;
                s1_a <= addr1;
                s1_d <= data1;
            end else if (g1) begin
                s1_v <= 1'b0;
            end
            // A freshly loaded slot is younger than one left standing; on a double load port 0 is older.
            if (ld0 && !ld1) begin
                age <= 1'b1;
            end else if (ld1) begin
                age <= 1'b0;
            end
            if (we3) begin
                lg <= g1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: round-robin and fixed-priority instances share stimulus and
// are compared each cycle against a timestamp-based model of the pending requests.
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v0, v1;
    logic [4:0]  addr0, addr1, ra1, ra2;
    logic [31:0] data0, data1;

    logic [1:0]       rdy0_w, rdy1_w, we3_w, haz1_w, haz2_w;
    logic [1:0][4:0]  a3_w;
    logic [1:0][31:0] wd3_w;

    int checks = 0;
    int errors = 0;

    // Register files fed by each DUT's write port; unwritten registers stay X on both sides.
    logic [31:0] rf_dut[2][32];
    logic [31:0] rf_exp[2][32];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (we3_w[i]) rf_dut[i][a3_w[i]] <= wd3_w[i];
        end
    end

    regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .RR(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .v0(v0), .rdy0(rdy0_w[0]), .addr0(addr0), .data0(data0),
        .v1(v1), .rdy1(rdy1_w[0]), .addr1(addr1), .data1(data1),
        .a1(ra1), .a2(ra2),
        .we3(we3_w[0]), .a3(a3_w[0]), .wd3(wd3_w[0]),
        .haz1(haz1_w[0]), .haz2(haz2_w[0])
    );

    regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .RR(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .v0(v0), .rdy0(rdy0_w[1]), .addr0(addr0), .data0(data0),
        .v1(v1), .rdy1(rdy1_w[1]), .addr1(addr1), .data1(data1),
        .a1(ra1), .a2(ra2),
        .we3(we3_w[1]), .a3(a3_w[1]), .wd3(wd3_w[1]),
        .haz1(haz1_w[1]), .haz2(haz2_w[1])
    );

    // Model: each pending request carries its arrival number; index 0 = RR instance, 1 = fixed.
    logic        pv[2][2];
    logic [4:0]  pa[2][2];
    logic [31:0] pd[2][2];
    int          ps[2][2];
    int          last_port[2];
    int          seqn = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input int i);
        if (!pv[i][0] && !pv[i][1]) return -1;
        if (pv[i][0] && !pv[i][1]) return 0;
        if (pv[i][1] && !pv[i][0]) return 1;
        if (pa[i][0] == pa[i][1]) return (ps[i][0] < ps[i][1]) ? 0 : 1;
        if (i == 0) return (last_port[i] == 0) ? 1 : 0;
        return 0;
    endfunction

    function automatic logic model_haz(input int i, input logic [4:0] ra);
        return (ra != 5'd0) && ((pv[i][0] && pa[i][0] == ra) || (pv[i][1] && pa[i][1] == ra));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            pv[i][0] = 1'b0;
            pv[i][1] = 1'b0;
            last_port[i] = 1;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            int g;
            g = model_grant(i);
            chk($sformatf("rdy0[%0d]", i), 32'(rdy0_w[i]), 32'(!pv[i][0] || g == 0));
            chk($sformatf("rdy1[%0d]", i), 32'(rdy1_w[i]), 32'(!pv[i][1] || g == 1));
            chk($sformatf("we3[%0d]", i), 32'(we3_w[i]), 32'(g >= 0));
            chk($sformatf("a3[%0d]", i), 32'(a3_w[i]), (g >= 0) ? 32'(pa[i][g[0]]) : 32'd0);
            chk($sformatf("wd3[%0d]", i), wd3_w[i], (g >= 0) ? pd[i][g[0]] : 32'd0);
            chk($sformatf("haz1[%0d]", i), 32'(haz1_w[i]), 32'(model_haz(i, ra1)));
            chk($sformatf("haz2[%0d]", i), 32'(haz2_w[i]), 32'(model_haz(i, ra2)));
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int   g;
            logic l0, l1;
            g  = model_grant(i);
            l0 = v0 && (!pv[i][0] || g == 0) && addr0 != 5'd0;
            l1 = v1 && (!pv[i][1] || g == 1) && addr1 != 5'd0;
            if (g >= 0) begin
                rf_exp[i][pa[i][g[0]]] = pd[i][g[0]];
                pv[i][g[0]] = 1'b0;
                last_port[i] = g;
            end
            if (l0) begin
                pv[i][0] = 1'b1; pa[i][0] = addr0; pd[i][0] = data0; ps[i][0] = seqn;
            end
            if (l1) begin
                pv[i][1] = 1'b1; pa[i][1] = addr1; pd[i][1] = data1; ps[i][1] = seqn + 1;
            end
        end
        seqn += 2;
    endtask

    task automatic step(input logic iv0, input logic [4:0] ia0, input logic [31:0] id0,
                        input logic iv1, input logic [4:0] ia1, input logic [31:0] id1,
                        input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        v0 = iv0; addr0 = ia0; data0 = id0;
        v1 = iv1; addr1 = ia1; data1 = id1;
        ra1 = r1; ra2 = r2;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] r2);
        for (int k = 0; k < n; k++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
    endtask

    initial begin
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        ra1 = 5'd3; ra2 = 5'd4;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // Single write, then read-back through the bench register file
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        idle(2, 5'd5, 5'd0);
        #2;
        chk("readback_r5", rf_dut[0][5], 32'hDEADBEEF);

        // Both ports held with different addresses
        for (int k = 0; k < 8; k++) step(1'b1, 5'd3, 32'(k), 1'b1, 5'd4, 32'(k + 100), 5'd3, 5'd4);
        idle(3, 5'd0, 5'd0);

        // Same-address ordering: port 1 first, port 0 one cycle later
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11, 5'd7, 5'd0);
        step(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        idle(3, 5'd7, 5'd0);
        #2;
        chk("order_r7_rr", rf_dut[0][7], 32'h22);
        chk("order_r7_fp", rf_dut[1][7], 32'h22);

        // Same-address in the reverse direction while the other slot is busy
        step(1'b1, 5'd8, 32'hA1, 1'b1, 5'd9, 32'hB1, 5'd8, 5'd9);
        step(1'b1, 5'd9, 32'hA2, 1'b1, 5'd8, 32'hB2, 5'd8, 5'd9);
        idle(4, 5'd9, 5'd8);

        // $0 write is accepted and dropped
        step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        idle(2, 5'd0, 5'd0);

        // Hazard on a slot holding r9
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0);
        idle(2, 5'd9, 5'd0);

        // Reset with both slots loaded: pending contents are dropped
        step(1'b1, 5'd6, 32'h66, 1'b1, 5'd10, 32'hAA, 5'd6, 5'd10);
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic on a small address range to force collisions and $0 requests
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end
        idle(3, 5'd0, 5'd0);
        #2;
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 32; r++) begin
                chk($sformatf("rf[%0d][%0d]", i, r), rf_dut[i][r], rf_exp[i][r]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
